// File: rtl/reg_axil_bridge.sv
// AXI4-Lite slave driving the 16-bit-address / 64-bit-data register-manager bus.
// One transaction in flight; strobes are single-cycle and separated by a minimum idle gap.
module reg_axil_bridge #(
  parameter int AXI_ADDR_W = 32,
  parameter int RD_LATENCY = 8,
  parameter int MIN_GAP    = 6
) (
  input  logic                  ps_clk,
  input  logic                  ps_rst,
  input  logic [AXI_ADDR_W-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [63:0]           s_axi_wdata,
  input  logic [7:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [AXI_ADDR_W-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [63:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  o_reg_wen,
  output logic [15:0]           o_reg_waddr,
  output logic [63:0]           o_reg_wdata,
  output logic                  o_reg_ren,
  output logic [15:0]           o_reg_raddr,
  input  logic [63:0]           i_reg_rdata,
  output logic                  o_busy
);

  if (RD_LATENCY < 2 || RD_LATENCY > 63 || MIN_GAP < 1 || MIN_GAP > 63 || AXI_ADDR_W < 16)
  begin : g_param_check
    $error("reg_axil_bridge: parameter out of range");
  end

  if (AXI_ADDR_W > 16) begin : g_hi_addr
    logic w_unused_hi;
    assign w_unused_hi = ^{s_axi_awaddr[AXI_ADDR_W-1:16], s_axi_araddr[AXI_ADDR_W-1:16]};
  end

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [5:0] LAT_LOAD    = 6'(RD_LATENCY - 1);
  localparam logic [5:0] GAP_LOAD    = 6'(MIN_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_STROBE, S_WR_RESP, S_RD_STROBE, S_RD_WAIT, S_RD_RESP, S_GAP
  } state_t;

  state_t      r_state, w_next;
  logic [5:0]  r_gap, r_lat;
  logic        r_last_rd, r_wr_err;
  logic [1:0]  r_bresp, r_rresp;
  logic [63:0] r_rdata, r_wdata;
  logic [15:0] r_waddr, r_raddr;

  logic w_idle, w_wr_elig, w_rd_elig, w_sel_wr, w_sel_rd, w_wr_bad, w_rd_bad;

  // Ready is only raised for the channel actually chosen, so a losing channel never handshakes.
  assign w_idle    = (r_state == S_IDLE) && (r_gap == '0) && !ps_rst;
  assign w_wr_elig = s_axi_awvalid && s_axi_wvalid;
  assign w_rd_elig = s_axi_arvalid;
  assign w_sel_wr  = w_idle && w_wr_elig && (!w_rd_elig || r_last_rd);
  assign w_sel_rd  = w_idle && w_rd_elig && (!w_wr_elig || !r_last_rd);
  assign w_wr_bad  = (s_axi_awaddr[2:0] != 3'd0) || (s_axi_wstrb != 8'hFF);
  assign w_rd_bad  = (s_axi_araddr[2:0] != 3'd0);

  always_ff @(posedge ps_clk or posedge ps_rst) begin
    if (ps_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_sel_wr)      w_next = S_WR_STROBE;
        else if (w_sel_rd) w_next = w_rd_bad ? S_RD_RESP : S_RD_STROBE;
      end
      S_WR_STROBE: w_next = S_WR_RESP;
      S_WR_RESP:   if (s_axi_bready) w_next = S_GAP;
      S_RD_STROBE: w_next = S_RD_WAIT;
      S_RD_WAIT:   if (r_lat == '0) w_next = S_RD_RESP;
      S_RD_RESP:   if (s_axi_rready) w_next = S_GAP;
      S_GAP:       if (r_gap == '0) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ps_clk or posedge ps_rst) begin
    if (ps_rst) begin
      r_gap     <= '0;
      r_lat     <= '0;
      r_last_rd <= 1'b1;
      r_wr_err  <= 1'b0;
      r_bresp   <= '0;
      r_rresp   <= '0;
      r_rdata   <= '0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_raddr   <= '0;
    end else begin
      if (w_sel_wr) begin
        r_last_rd <= 1'b0;
        r_wr_err  <= w_wr_bad;
        r_bresp   <= w_wr_bad ? RESP_SLVERR : RESP_OKAY;
        if (!w_wr_bad) begin
          r_waddr <= s_axi_awaddr[15:0];
          r_wdata <= s_axi_wdata;
        end
      end
      if (w_sel_rd) begin
        r_last_rd <= 1'b1;
        if (w_rd_bad) begin
          r_rdata <= '0;
          r_rresp <= RESP_SLVERR;
        end else begin
          r_raddr <= s_axi_araddr[15:0];
          r_rresp <= RESP_OKAY;
        end
      end
      if (r_state == S_RD_STROBE) begin
        r_lat <= LAT_LOAD;
      end else if (r_state == S_RD_WAIT) begin
        if (r_lat == '0) r_rdata <= i_reg_rdata;
        else             r_lat   <= r_lat - 6'd1;
      end
      if ((r_state == S_WR_RESP && s_axi_bready) || (r_state == S_RD_RESP && s_axi_rready))
        r_gap <= GAP_LOAD;
      else if (r_state == S_GAP && r_gap != '0)
        r_gap <= r_gap - 6'd1;
    end
  end

  assign s_axi_awready = w_sel_wr;
  assign s_axi_wready  = w_sel_wr;
  assign s_axi_arready = w_sel_rd;
  assign s_axi_bvalid  = (r_state == S_WR_RESP);
  assign s_axi_bresp   = r_bresp;
  assign s_axi_rvalid  = (r_state == S_RD_RESP);
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rdata   = r_rdata;
  assign o_reg_wen     = (r_state == S_WR_STROBE) && !r_wr_err;
  assign o_reg_waddr   = r_waddr;
  assign o_reg_wdata   = r_wdata;
  assign o_reg_ren     = (r_state == S_RD_STROBE);
  assign o_reg_raddr   = r_raddr;
  assign o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_reg_axil_bridge.sv
// Scoreboard bench for reg_axil_bridge: stimulus pushes expected strobes/responses,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_reg_axil_bridge;
  localparam int RD_LATENCY = 8;
  localparam int MIN_GAP    = 6;

  logic        ps_clk, ps_rst;
  logic [31:0] s_axi_awaddr, s_axi_araddr;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [63:0] s_axi_wdata, s_axi_rdata, i_reg_rdata;
  logic [7:0]  s_axi_wstrb;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready;
  logic        o_reg_wen, o_reg_ren, o_busy;
  logic [15:0] o_reg_waddr, o_reg_raddr;
  logic [63:0] o_reg_wdata;

  reg_axil_bridge #(.AXI_ADDR_W(32), .RD_LATENCY(RD_LATENCY), .MIN_GAP(MIN_GAP)) dut (
    .ps_clk(ps_clk), .ps_rst(ps_rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .o_reg_wen(o_reg_wen), .o_reg_waddr(o_reg_waddr), .o_reg_wdata(o_reg_wdata),
    .o_reg_ren(o_reg_ren), .o_reg_raddr(o_reg_raddr), .i_reg_rdata(i_reg_rdata),
    .o_busy(o_busy)
  );

  typedef struct { bit rd; logic [15:0] addr; logic [63:0] data; } stb_t;
  typedef struct { logic [63:0] data; logic [1:0] resp; } rsp_t;

  stb_t        q_stb[$];
  logic [1:0]  q_b[$];
  rsp_t        q_r[$];
  int          n_err = 0;
  int          n_chk = 0;
  int          cyc = 0;
  int          ren_cyc = -1000;
  int          last_stb = -1;
  int          b_hs_cyc = 0;
  logic [63:0] rd_val = '0;
  int          acc, acc2;
  bit          seen, any;

  initial begin
    ps_clk = 0;
    forever #5 ps_clk = ~ps_clk;
  end

  always @(posedge ps_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: DUT presented an event with nothing expected (cycle %0d)", name, cyc);
  endtask

  // Register-manager model: read data is valid only in the cycle RD_LATENCY after the strobe.
  initial forever begin
    @(negedge ps_clk);
    if (o_reg_ren) ren_cyc = cyc;
    i_reg_rdata = (cyc == ren_cyc + RD_LATENCY) ? rd_val : ~rd_val;
  end

  always @(negedge ps_clk) begin
    stb_t e;
    rsp_t r;
    if (o_reg_wen && o_reg_ren) unexpected("wen_ren_overlap");
    if (o_reg_wen || o_reg_ren) begin
      if (last_stb >= 0) chk("strobe_gap", ((cyc - last_stb) > MIN_GAP), 1'b1);
      last_stb = cyc;
    end
    if (o_reg_wen) begin
      if (q_stb.size() == 0) unexpected("wen");
      else begin
        e = q_stb.pop_front();
        chk("wen", {1'b0, o_reg_waddr, o_reg_wdata}, {e.rd, e.addr, e.data});
      end
    end
    if (o_reg_ren) begin
      if (q_stb.size() == 0) unexpected("ren");
      else begin
        e = q_stb.pop_front();
        chk("ren", {1'b1, o_reg_raddr}, {e.rd, e.addr});
      end
    end
    if (s_axi_bvalid && s_axi_bready) begin
      b_hs_cyc = cyc;
      if (q_b.size() == 0) unexpected("bresp");
      else chk("bresp", s_axi_bresp, q_b.pop_front());
    end
    if (s_axi_rvalid && s_axi_rready) begin
      if (q_r.size() == 0) unexpected("rresp");
      else begin
        r = q_r.pop_front();
        chk("rresp", {s_axi_rdata, s_axi_rresp}, {r.data, r.resp});
      end
    end
  end

  function automatic void exp_write(input logic [15:0] a, input logic [63:0] d, input logic [7:0] s);
    stb_t e;
    if (a[2:0] != 3'd0 || s != 8'hFF) q_b.push_back(2'b10);
    else begin
      e.rd = 1'b0; e.addr = a; e.data = d;
      q_stb.push_back(e);
      q_b.push_back(2'b00);
    end
  endfunction

  function automatic void exp_read(input logic [15:0] a, input logic [63:0] d);
    stb_t e;
    rsp_t r;
    if (a[2:0] != 3'd0) begin
      r.data = '0; r.resp = 2'b10;
    end else begin
      e.rd = 1'b1; e.addr = a; e.data = '0;
      q_stb.push_back(e);
      r.data = d; r.resp = 2'b00;
    end
    q_r.push_back(r);
  endfunction

  task automatic axi_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                           output int acc_c);
    bit done = 0;
    acc_c = -1;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1; s_axi_wvalid = 1;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge ps_clk);
      if (s_axi_awready && s_axi_wready) begin acc_c = cyc; done = 1; end
    end
    if (!done) begin
      n_chk++; n_err++;
      $display("FAIL aw_timeout: addr %0h not accepted, required within 500 cycles", a);
    end
    @(posedge ps_clk); #1;
    s_axi_awvalid = 0; s_axi_wvalid = 0;
  endtask

  task automatic axi_read(input logic [31:0] a, output int acc_c);
    bit done = 0;
    acc_c = -1;
    s_axi_araddr = a; s_axi_arvalid = 1;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge ps_clk);
      if (s_axi_arready) begin acc_c = cyc; done = 1; end
    end
    if (!done) begin
      n_chk++; n_err++;
      $display("FAIL ar_timeout: addr %0h not accepted, required within 500 cycles", a);
    end
    @(posedge ps_clk); #1;
    s_axi_arvalid = 0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge ps_clk);
      if (!o_busy && q_stb.size() == 0 && q_b.size() == 0 && q_r.size() == 0) done = 1;
    end
    if (!done) begin
      n_chk++; n_err++;
      $display("FAIL drain_timeout: busy=%0b pending stb=%0d b=%0d r=%0d, required all idle",
               o_busy, q_stb.size(), q_b.size(), q_r.size());
    end
    @(posedge ps_clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required to end on its own");
    $fatal(1, "watchdog");
  end

  initial begin
    ps_rst = 1;
    s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 0;
    s_axi_bready = 1; s_axi_araddr = '0; s_axi_arvalid = 0; s_axi_rready = 1;
    repeat (3) @(posedge ps_clk);
    #1;
    chk("reset_outputs", |{s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid, s_axi_arready,
                           s_axi_rdata, s_axi_rresp, s_axi_rvalid, o_reg_wen, o_reg_waddr,
                           o_reg_wdata, o_reg_ren, o_reg_raddr, o_busy}, 1'b0);
    ps_rst = 0;
    @(posedge ps_clk); #1;

    // Simultaneous write+read after reset: write first, then read.
    rd_val = 64'h1111_2222_3333_4444;
    exp_write(16'h0060, 64'hDEAD_BEEF_0000_0001, 8'hFF);
    exp_read(16'h0068, rd_val);
    fork
      axi_write(32'h0000_0060, 64'hDEAD_BEEF_0000_0001, 8'hFF, acc);
      axi_read(32'h0000_0068, acc2);
    join
    chk("arb_write_first", (acc < acc2), 1'b1);
    wait_idle();
    exp_write(16'h0070, 64'h0123_4567_89AB_CDEF, 8'hFF);
    axi_write(32'h0000_0070, 64'h0123_4567_89AB_CDEF, 8'hFF, acc);
    wait_idle();
    // Last served was a write, so a simultaneous pair now goes read first.
    rd_val = 64'h5555_6666_7777_8888;
    exp_read(16'h0078, rd_val);
    exp_write(16'h0080, 64'hCAFE_F00D_0000_0002, 8'hFF);
    fork
      axi_write(32'h0000_0080, 64'hCAFE_F00D_0000_0002, 8'hFF, acc);
      axi_read(32'h0000_0078, acc2);
    join
    chk("arb_read_first", (acc2 < acc), 1'b1);
    wait_idle();

    // Good write, then error writes issued back-to-back; acceptance waits out the gap.
    exp_write(16'h0020, 64'h0000_0000_8000_0000, 8'hFF);
    axi_write(32'h0000_0020, 64'h0000_0000_8000_0000, 8'hFF, acc);
    exp_write(16'h0028, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    axi_write(32'h0000_0028, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, acc);
    chk("aw_gap", acc - b_hs_cyc, MIN_GAP + 1);
    exp_write(16'h0024, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
    axi_write(32'h0000_0024, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, acc);
    wait_idle();
    chk("held_wr", {o_reg_waddr, o_reg_wdata}, {16'h0020, 64'h0000_0000_8000_0000});

    // Read with exact latency window, then a misaligned read.
    rd_val = 64'h9000_0000_0000_03FF;
    exp_read(16'h0038, rd_val);
    axi_read(32'h0000_0038, acc);
    wait_idle();
    exp_read(16'h003C, rd_val);
    axi_read(32'h0000_003C, acc);
    wait_idle();

    // rready held low: response must hold and nothing else may be accepted.
    rd_val = 64'hA5A5_0000_1234_5678;
    exp_read(16'h0040, rd_val);
    exp_write(16'h0048, 64'h0000_1111_2222_3333, 8'hFF);
    s_axi_rready = 0;
    axi_read(32'h0000_0040, acc);
    fork
      axi_write(32'h0000_0048, 64'h0000_1111_2222_3333, 8'hFF, acc2);
      begin
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
          @(negedge ps_clk);
          if (s_axi_rvalid) seen = 1;
        end
        chk("rvalid_seen", seen, 1'b1);
        repeat (20) begin
          @(negedge ps_clk);
          chk("rready_hold", {s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_arready,
                              s_axi_awready, o_reg_wen, o_reg_ren},
                             {1'b1, rd_val, 2'b00, 4'b0000});
        end
        @(posedge ps_clk); #1;
        s_axi_rready = 1;
      end
    join
    wait_idle();

    // Reset during RD_WAIT aborts the read; the next read completes normally.
    rd_val = 64'h0BAD_0BAD_0BAD_0BAD;
    exp_read(16'h0050, rd_val);
    axi_read(32'h0000_0050, acc);
    repeat (3) @(posedge ps_clk);
    #1;
    ps_rst = 1;
    #1;
    chk("midreset_outputs", |{s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid, s_axi_arready,
                              s_axi_rdata, s_axi_rresp, s_axi_rvalid, o_reg_wen, o_reg_waddr,
                              o_reg_wdata, o_reg_ren, o_reg_raddr, o_busy}, 1'b0);
    q_r.delete();
    repeat (2) @(posedge ps_clk);
    #1;
    ps_rst = 0;
    any = 0;
    repeat (RD_LATENCY + 4) begin
      @(negedge ps_clk);
      any = any | s_axi_rvalid | o_busy;
    end
    chk("no_rvalid_after_reset", any, 1'b0);
    @(posedge ps_clk); #1;
    rd_val = 64'h7E57_0000_C0DE_0006;
    exp_read(16'h0058, rd_val);
    axi_read(32'h0000_0058, acc);
    wait_idle();

    chk("queues_empty", {32'(q_stb.size()), 32'(q_b.size()), 32'(q_r.size())}, '0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
